// File: rtl/mul_dot_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mul_dot_sched
//  Description : Signed dot-product sequencer. Streams operand pairs from two
//                operand RAMs into the shared 17-bit pipelined multiplier and
//                accumulates the products with saturation into one result per
//                command, returned over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_dot_sched #(
  parameter int ADDR_W  = 10,
  parameter int MUL_LAT = 10,
  parameter int RD_LAT  = 1,
  parameter int ACC_W   = 44
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              abort,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [16:0]       ram_dout_a,
  input  logic [16:0]       ram_dout_b,
  output logic              mul_enable,
  output logic              mul_start,
  output logic [16:0]       mul_a,
  output logic [16:0]       mul_b,
  input  logic [31:0]       mul_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  output logic              busy
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_a_q, base_a_d;
  logic [ADDR_W-1:0]   base_b_q, base_b_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ADDR_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic                op_vld_q, op_vld_d;
  logic [MUL_LAT-1:0]  tag_q, tag_d;
  logic [16:0]         mul_a_q, mul_a_d;
  logic [16:0]         mul_b_q, mul_b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                sat_q, sat_d;
  logic [ACC_W:0]      sum_w;

  // The multiplier's sign-magnitude stage has no +65536, so -65536 is
  // pulled in by one LSB.
  function automatic logic [16:0] clamp_op(input logic [16:0] v);
    return (v == 17'h10000) ? 17'h10001 : v;
  endfunction

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign res_data = acc_q;
  assign res_sat  = sat_q;

  // One guard bit above the accumulator exposes signed overflow.
  assign sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-32){mul_data[31]}}, mul_data};

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    len_d      = len_q;
    k_d        = k_q;
    acc_cnt_d  = acc_cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;

    cmd_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    res_valid  = (state_q == S_DONE);
    ram_rd_en  = (state_q == S_ISSUE) && !abort;
    ram_addr_a = ram_rd_en ? (base_a_q + k_q) : '0;
    ram_addr_b = ram_rd_en ? (base_b_q + k_q) : '0;
    mul_enable = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !abort;
    mul_start  = mul_enable;

    // Read strobe travels RD_LAT stages to mark when RAM data is valid;
    // operands are registered on that cycle and tagged for the multiplier.
    rd_pipe_d  = (rd_pipe_q << 1) | RD_LAT'(ram_rd_en);
    op_vld_d   = rd_pipe_q[RD_LAT-1];
    mul_a_d    = rd_pipe_q[RD_LAT-1] ? clamp_op(ram_dout_a) : '0;
    mul_b_d    = rd_pipe_q[RD_LAT-1] ? clamp_op(ram_dout_b) : '0;
    tag_d      = (tag_q << 1) | MUL_LAT'(op_vld_q);

    // A tag emerging from the pipe means mul_data holds a wanted product.
    if (tag_q[MUL_LAT-1]) begin
      acc_cnt_d = acc_cnt_q + ADDR_W'(1);
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        acc_d = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && !abort) begin
          base_a_d  = cmd_base_a;
          base_b_d  = cmd_base_b;
          len_d     = cmd_len;
          k_d       = '0;
          acc_cnt_d = '0;
          acc_d     = '0;
          sat_d     = 1'b0;
          state_d   = (cmd_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        k_d = k_q + ADDR_W'(1);
        if (k_q == len_q - ADDR_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tag_q[MUL_LAT-1] && (acc_cnt_d == len_q)) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a coincident result handshake.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      rd_pipe_d = '0;
      op_vld_d  = 1'b0;
      mul_a_d   = '0;
      mul_b_d   = '0;
      tag_d     = '0;
      acc_d     = '0;
      acc_cnt_d = '0;
      k_d       = '0;
      sat_d     = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_a_q  <= '0;
      base_b_q  <= '0;
      len_q     <= '0;
      k_q       <= '0;
      acc_cnt_q <= '0;
      rd_pipe_q <= '0;
      op_vld_q  <= 1'b0;
      tag_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      len_q     <= len_d;
      k_q       <= k_d;
      acc_cnt_q <= acc_cnt_d;
      rd_pipe_q <= rd_pipe_d;
      op_vld_q  <= op_vld_d;
      tag_q     <= tag_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
    end
  end

endmodule
`default_nettype wire
